float_normalizer: RTL

FLOAT_NORMALIZER -- requirements
Module: float_normalizer

---
 rtl/float8_pkg.sv | 9 +
 rtl/norm_step.sv | 31 +++
 rtl/float_normalizer.sv | 71 +++++++
 3 files changed

// File: rtl/float8_pkg.sv
// float8_pkg: shared float8 widths, exponent bias, normalizer states and packed result constants.
package float8_pkg;
  localparam int EXP_W = 3;
  localparam int FRAC_W = 4;
  localparam int BIAS = 3;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [EXP_W+FRAC_W-1:0] SAT_MAG = '1;
  localparam logic [EXP_W+FRAC_W:0] ZERO_NUM = '0;
endpackage

// File: rtl/norm_step.sv
// norm_step: one combinational normalization step; FLOAT_NORMALIZER_ROUND_EN selects half-up rounding on right shifts.
module norm_step import float8_pkg::*; #(
  parameter int EXP_W = float8_pkg::EXP_W,
  parameter int FRAC_W = float8_pkg::FRAC_W
) (
  input  logic [FRAC_W+1:0] frac,
  input  logic [EXP_W-1:0]  expo,
  output logic [FRAC_W+1:0] nfrac,
  output logic [EXP_W-1:0]  nexpo,
  output logic              done,
  output logic              ovf,
  output logic              unf
);
  localparam logic [EXP_W-1:0] EMAX = '1;
  logic [FRAC_W+1:0] rsum;
  logic [FRAC_W+1:0] rnd;
  logic              carry;
`ifdef FLOAT_NORMALIZER_ROUND_EN
  assign rsum = {1'b0, frac[FRAC_W+1:1]} + (FRAC_W+2)'(frac[0]);
`else
  assign rsum = {1'b0, frac[FRAC_W+1:1]};
`endif
  // a rounding carry renormalizes to 01.0000 and bumps the exponent once more
  assign carry = rsum[FRAC_W+1];
  assign rnd   = carry ? {2'b01, {FRAC_W{1'b0}}} : rsum;
  assign done  = frac[FRAC_W+1:FRAC_W] == 2'b01;
  assign ovf   = frac[FRAC_W+1] && (expo == EMAX || (carry && expo == EMAX - EXP_W'(1)));
  assign unf   = frac[FRAC_W+1:FRAC_W] == 2'b00 && expo == '0;
  assign nfrac = frac[FRAC_W+1] ? rnd : frac << 1;
  assign nexpo = frac[FRAC_W+1] ? expo + EXP_W'(1) + EXP_W'(carry) : expo - EXP_W'(1);
endmodule

// File: rtl/float_normalizer.sv
// float_normalizer: iterative post-add normalizer with ready/valid handshakes; FLOAT_NORMALIZER_ROUND_EN enables right-shift rounding.
module float_normalizer import float8_pkg::*; #(
  parameter int EXP_W = float8_pkg::EXP_W,
  parameter int FRAC_W = float8_pkg::FRAC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_expo,
  input  logic [FRAC_W+1:0]       in_frac,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_number,
  output logic                    out_overflow,
  output logic                    out_underflow
);
  state_t                 state, state_n;
  logic                   sign_r;
  logic [EXP_W-1:0]       expo_r, nexpo;
  logic [FRAC_W+1:0]      frac_r, nfrac;
  logic [EXP_W+FRAC_W:0]  res;
  logic                   ovf_r, unf_r, done, ovf, unf;
  norm_step #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_step (
    .frac(frac_r), .expo(expo_r), .nfrac(nfrac), .nexpo(nexpo), .done(done), .ovf(ovf), .unf(unf)
  );
  always_comb begin
    state_n = state == IDLE  ? (in_valid ? (in_frac == '0 ? DONE : SHIFT) : IDLE)
            : state == SHIFT ? (done || ovf || unf ? DONE : SHIFT)
            : (out_valid && out_ready ? IDLE : DONE);
  end
  // out_valid lags DONE entry by one cycle so the result sits in a register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      res       <= '0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= state == DONE && !(out_valid && out_ready);
      if (state == IDLE && in_valid) begin
        sign_r <= in_sign;
        expo_r <= in_expo;
        frac_r <= in_frac;
        res    <= '0;
        ovf_r  <= 1'b0;
        unf_r  <= 1'b0;
      end else if (state == SHIFT) begin
        if (ovf) begin
          res   <= {sign_r, {(EXP_W+FRAC_W){1'b1}}};
          ovf_r <= 1'b1;
        end else if (unf) begin
          res   <= '0;
          unf_r <= 1'b1;
        end else if (done) begin
          res <= {sign_r, expo_r, frac_r[FRAC_W-1:0]};
        end else begin
          frac_r <= nfrac;
          expo_r <= nexpo;
        end
      end
    end
  end
  assign in_ready      = state == IDLE;
  assign out_number    = out_valid ? res : '0;
  assign out_overflow  = out_valid && ovf_r;
  assign out_underflow = out_valid && unf_r;
endmodule
